// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and constants for the RV32I instruction fetch stage.
//   fetch_state_e    : fetch FSM states (FETCH, HOLD, DRAIN)
//   if_op_e          : update applied to the IF/ID register in a given cycle
//   NOP_INSTR        : canonical NOP (addi x0, x0, 0) shown by an empty IF/ID
//   DEFAULT_RESET_PC : default for the fetch_stage RESET_PC parameter
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding at the current PC
    HOLD  = 2'd1,  // fetched word parked in the skid buffer while decode stalls
    DRAIN = 2'd2   // waiting out a request made stale by a redirect
  } fetch_state_e;

  typedef enum logic [2:0] {
    IF_HOLD      = 3'd0,  // keep current contents (stall)
    IF_BUBBLE    = 3'd1,  // advance with nothing new: mark invalid
    IF_FROM_MEM  = 3'd2,  // load the word acked this cycle
    IF_FROM_SKID = 3'd3,  // load the word parked in the skid buffer
    IF_FLUSH     = 3'd4   // redirect: invalidate and show NOP
  } if_op_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf -- one-entry {instr, pc} holding buffer. Catches a fetched
// word that arrives while the IF/ID register is stalled so the memory
// handshake can complete without losing the word.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : capture i_instr/i_pc and mark the entry valid
//   i_clear        : drop the entry (wins over i_load)
//   i_instr, i_pc  : word and its address to capture
//   o_valid        : entry holds a word
//   o_instr, o_pc  : stored word and its address
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  // NOTE: the data fields are reset too; it is a single entry, so a defined
  // power-up value costs nothing and keeps X out of the IF/ID mux.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_instr <= NOP_INSTR;
      o_pc    <= '0;
    end else if (i_clear) begin
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_instr <= i_instr;
      o_pc    <= i_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage -- RV32I instruction fetch stage and IF/ID pipeline register.
// Owns the PC, fetches words over a req/ack handshake (req and addr held
// until ack, zero-wait ack allowed) and presents {instr, pc, pc+4} to decode.
// Stall holds IF/ID; a redirect from execute flushes IF/ID and restarts fetch
// at the (word-aligned) target, draining any request already in flight.
// Parameter:
//   RESET_PC (word aligned) : PC after reset
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_stall                 : hazard unit holds IF/ID
//   i_redirect, i_redirect_pc : flush + new fetch target
//   o_imem_req, o_imem_addr : fetch request / word address
//   i_imem_ack, i_imem_rdata: fetch response
//   o_if_valid, o_if_instr, o_if_pc, o_if_pc4 : IF/ID register to decode
//   o_misalign              : one-cycle flag for a misaligned redirect target
// Build option:
//   FETCH_MISALIGN_CHK_EN   : when defined, o_misalign reports redirects whose
//                             target has nonzero low bits; otherwise tied to 0.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_pc4,
  output logic        o_misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic         run_q;
  if_op_e       if_op;
  logic         skid_load, skid_clear;
  logic         skid_valid;
  logic [31:0]  skid_instr, skid_pc;
  logic         ack;

  // run_q keeps req low until the first edge after reset release, so a
  // request never appears in the same cycle the reset is let go.
  assign o_imem_req  = run_q && (state_q != HOLD);
  assign o_imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign ack         = o_imem_req && i_imem_ack;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statements leaves one unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    if_op        = i_stall ? IF_HOLD : IF_BUBBLE;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;

    if (i_redirect) begin
      // Redirect beats stall and any ack this cycle; acked data is dropped.
      pc_d       = {i_redirect_pc[31:2], 2'b00};
      if_op      = IF_FLUSH;
      skid_clear = 1'b1;
      if (o_imem_req && !ack) begin
        state_d = DRAIN;
        // In DRAIN the stale address is already captured; only the PC moves.
        if (state_q != DRAIN) drain_addr_d = pc_q;
      end else begin
        state_d = FETCH;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ack) begin
            if (i_stall) begin
              skid_load = 1'b1;
              state_d   = HOLD;
            end else begin
              if_op = IF_FROM_MEM;
              pc_d  = pc_q + 32'd4;
            end
          end
        end
        HOLD: begin
          if (!i_stall) begin
            if_op      = skid_valid ? IF_FROM_SKID : IF_BUBBLE;
            skid_clear = 1'b1;
            pc_d       = pc_q + 32'd4;
            state_d    = FETCH;
          end
        end
        DRAIN: begin
          if (ack) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      run_q        <= 1'b1;
    end
  end

  // IF/ID register. A stall holds it even when it is invalid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_if_valid <= 1'b0;
      o_if_instr <= NOP_INSTR;
      o_if_pc    <= RESET_PC;
    end else begin
      unique case (if_op)
        IF_FLUSH: begin
          o_if_valid <= 1'b0;
          o_if_instr <= NOP_INSTR;
        end
        IF_FROM_MEM: begin
          o_if_valid <= 1'b1;
          o_if_instr <= i_imem_rdata;
          o_if_pc    <= pc_q;
        end
        IF_FROM_SKID: begin
          o_if_valid <= 1'b1;
          o_if_instr <= skid_instr;
          o_if_pc    <= skid_pc;
        end
        IF_BUBBLE: o_if_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_if_pc4 = o_if_pc + 32'd4;

  fetch_skid_buf u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (skid_load),
    .i_clear (skid_clear),
    .i_instr (i_imem_rdata),
    .i_pc    (pc_q),
    .o_valid (skid_valid),
    .o_instr (skid_instr),
    .o_pc    (skid_pc)
  );

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) misalign_q <= 1'b0;
    else          misalign_q <= i_redirect && (i_redirect_pc[1:0] != 2'b00);
  end

  assign o_misalign = misalign_q;
`else
  // Low target bits are dropped silently in this build.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];
  assign o_misalign           = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage -- scoreboard bench for fetch_stage (RESET_PC = 0x100).
// The stimulus process pushes the expected fetch addresses and expected IF/ID
// words into queues; a monitor on the falling edge pops and compares whenever
// the DUT completes a fetch handshake or presents a newly loaded valid word.
// The bench memory returns 32'hA000_0000 | addr, with a programmable latency.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_exp_t;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        o_if_valid;
  logic [31:0] o_if_instr;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_pc4;
  logic        o_misalign;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ack    (i_imem_ack),
    .i_imem_rdata  (i_imem_rdata),
    .o_if_valid    (o_if_valid),
    .o_if_instr    (o_if_instr),
    .o_if_pc       (o_if_pc),
    .o_if_pc4      (o_if_pc4),
    .o_misalign    (o_misalign)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] addr_q[$];
  if_exp_t     if_q[$];

`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic [31:0] EXP_MISALIGN = 32'd1;
`else
  localparam logic [31:0] EXP_MISALIGN = 32'd0;
`endif

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: acks after `lat` wait cycles, never without req.
  logic mem_en;
  int   lat;
  int   mem_cnt;
  logic mem_pend;

  initial begin
    i_imem_ack   = 1'b0;
    i_imem_rdata = 32'h0;
    mem_cnt      = 0;
    mem_pend     = 1'b0;
  end

  always begin
    @(posedge i_clk);
    #2;
    if (!i_rst_n || !o_imem_req) begin
      mem_cnt    = 0;
      mem_pend   = 1'b0;
      i_imem_ack = 1'b0;
    end else begin
      mem_cnt    = mem_pend ? mem_cnt + 1 : 0;
      i_imem_ack = mem_en && (mem_cnt >= lat);
      mem_pend   = !i_imem_ack;
    end
    i_imem_rdata = i_imem_ack ? (32'hA000_0000 | o_imem_addr) : 32'hDEAD_BEEF;
  end

  // Monitor / scoreboard.
  logic        mon_pend;
  logic [31:0] mon_pend_addr;
  logic        mon_adv;
  logic [31:0] mon_a;
  if_exp_t     mon_e;

  initial begin
    mon_pend = 1'b0;
    mon_adv  = 1'b0;
  end

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      mon_pend = 1'b0;
      mon_adv  = 1'b0;
    end else begin
      if (mon_pend) begin
        check("hs_req_held", 32'(o_imem_req), 32'd1);
        check("hs_addr_held", o_imem_addr, mon_pend_addr);
      end
      if (o_imem_req && i_imem_ack) begin
        if (addr_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL fetch_addr: ack at %h, expected no fetch", o_imem_addr);
        end else begin
          mon_a = addr_q.pop_front();
          check("fetch_addr", o_imem_addr, mon_a);
        end
      end
      if (mon_adv && o_if_valid) begin
        if (if_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL if_word: valid pc %h, expected no word", o_if_pc);
        end else begin
          mon_e = if_q.pop_front();
          check("if_instr", o_if_instr, mon_e.instr);
          check("if_pc", o_if_pc, mon_e.pc);
          check("if_pc4", o_if_pc4, mon_e.pc + 32'd4);
        end
      end
      mon_pend      = o_imem_req && !i_imem_ack;
      mon_pend_addr = o_imem_addr;
      mon_adv       = !i_stall;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1, "watchdog expired");
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Leaves the bench in cycle C1, the first cycle with a request.
  task automatic do_reset(input int l);
    i_rst_n       = 1'b0;
    mem_en        = 1'b1;
    lat           = l;
    i_stall       = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    tick(2);
    check("rst_req", 32'(o_imem_req), 32'd0);
    check("rst_valid", 32'(o_if_valid), 32'd0);
    check("rst_instr", o_if_instr, 32'h0000_0013);
    check("rst_pc", o_if_pc, 32'h0000_0100);
    check("rst_pc4", o_if_pc4, 32'h0000_0104);
    check("rst_misalign", 32'(o_misalign), 32'd0);
    i_rst_n = 1'b1;
    check("release_req", 32'(o_imem_req), 32'd0);
    tick(1);
  endtask

  task automatic end_test();
    tick(2);
    check("addr_q_empty", 32'(addr_q.size()), 32'd0);
    check("if_q_empty", 32'(if_q.size()), 32'd0);
  endtask

  initial begin
    i_rst_n       = 1'b1;
    i_stall       = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    mem_en        = 1'b0;
    lat           = 0;
    @(posedge i_clk);
    #1;

    // 1: zero-wait memory, back-to-back fetches.
    addr_q = '{32'h100, 32'h104, 32'h108};
    if_q   = '{'{32'hA000_0100, 32'h100}, '{32'hA000_0104, 32'h104}, '{32'hA000_0108, 32'h108}};
    do_reset(0);
    check("t1_c1_req", 32'(o_imem_req), 32'd1);
    check("t1_c1_addr", o_imem_addr, 32'h100);
    check("t1_c1_valid", 32'(o_if_valid), 32'd0);
    tick(1);
    check("t1_c2_addr", o_imem_addr, 32'h104);
    check("t1_c2_valid", 32'(o_if_valid), 32'd1);
    check("t1_c2_pc", o_if_pc, 32'h100);
    tick(1);
    check("t1_c3_addr", o_imem_addr, 32'h108);
    check("t1_c3_pc", o_if_pc, 32'h104);
    tick(1);
    mem_en = 1'b0;
    check("t1_c4_pc", o_if_pc, 32'h108);
    end_test();

    // 2: three-cycle ack latency.
    addr_q = '{32'h100, 32'h104};
    if_q   = '{'{32'hA000_0100, 32'h100}, '{32'hA000_0104, 32'h104}};
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      check("t2_req_wait", 32'(o_imem_req), 32'd1);
      check("t2_addr_wait", o_imem_addr, 32'h100);
      tick(1);
    end
    check("t2_c4_addr", o_imem_addr, 32'h104);
    check("t2_c4_valid", 32'(o_if_valid), 32'd1);
    tick(1);
    check("t2_c5_valid", 32'(o_if_valid), 32'd0);
    tick(1);
    check("t2_c6_valid", 32'(o_if_valid), 32'd0);
    tick(1);
    mem_en = 1'b0;
    check("t2_c7_valid", 32'(o_if_valid), 32'd1);
    check("t2_c7_pc", o_if_pc, 32'h104);
    end_test();

    // 3: ack during a two-cycle stall goes to the skid buffer.
    addr_q = '{32'h100, 32'h104, 32'h108};
    if_q   = '{'{32'hA000_0100, 32'h100}, '{32'hA000_0104, 32'h104}, '{32'hA000_0108, 32'h108}};
    do_reset(0);
    tick(1);
    i_stall = 1'b1;
    check("t3_c2_pc", o_if_pc, 32'h100);
    tick(1);
    check("t3_hold_req", 32'(o_imem_req), 32'd0);
    check("t3_hold_pc", o_if_pc, 32'h100);
    check("t3_hold_instr", o_if_instr, 32'hA000_0100);
    check("t3_hold_valid", 32'(o_if_valid), 32'd1);
    tick(1);
    i_stall = 1'b0;
    check("t3_c4_req", 32'(o_imem_req), 32'd0);
    check("t3_c4_pc", o_if_pc, 32'h100);
    tick(1);
    check("t3_c5_pc", o_if_pc, 32'h104);
    check("t3_c5_instr", o_if_instr, 32'hA000_0104);
    check("t3_c5_addr", o_imem_addr, 32'h108);
    tick(1);
    mem_en = 1'b0;
    check("t3_c6_pc", o_if_pc, 32'h108);
    end_test();

    // 4: redirect to 0x200 while the fetch of 0x10C waits on a 2-cycle ack.
    addr_q = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h200};
    if_q   = '{'{32'hA000_0100, 32'h100}, '{32'hA000_0104, 32'h104},
               '{32'hA000_0108, 32'h108}, '{32'hA000_0200, 32'h200}};
    do_reset(1);
    tick(6);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h200;
    check("t4_c7_addr", o_imem_addr, 32'h10C);
    tick(1);
    i_redirect = 1'b0;
    check("t4_drain_req", 32'(o_imem_req), 32'd1);
    check("t4_drain_addr", o_imem_addr, 32'h10C);
    check("t4_drain_valid", 32'(o_if_valid), 32'd0);
    check("t4_drain_instr", o_if_instr, 32'h0000_0013);
    tick(1);
    check("t4_c9_addr", o_imem_addr, 32'h200);
    check("t4_c9_valid", 32'(o_if_valid), 32'd0);
    check("t4_c9_instr", o_if_instr, 32'h0000_0013);
    tick(1);
    check("t4_c10_valid", 32'(o_if_valid), 32'd0);
    tick(1);
    mem_en = 1'b0;
    check("t4_c11_pc", o_if_pc, 32'h200);
    end_test();

    // 5: redirect together with stall and an ack.
    addr_q = '{32'h100, 32'h104, 32'h240};
    if_q   = '{'{32'hA000_0100, 32'h100}, '{32'hA000_0240, 32'h240}};
    do_reset(0);
    tick(1);
    i_stall       = 1'b1;
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h240;
    tick(1);
    i_stall    = 1'b0;
    i_redirect = 1'b0;
    check("t5_flush_valid", 32'(o_if_valid), 32'd0);
    check("t5_flush_instr", o_if_instr, 32'h0000_0013);
    check("t5_c3_addr", o_imem_addr, 32'h240);
    tick(1);
    mem_en = 1'b0;
    check("t5_c4_pc", o_if_pc, 32'h240);
    end_test();

    // 6: redirect to a misaligned target.
    addr_q = '{32'h100, 32'h200};
    if_q   = '{'{32'hA000_0200, 32'h200}};
    do_reset(0);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h202;
    check("t6_c1_misalign", 32'(o_misalign), 32'd0);
    tick(1);
    i_redirect = 1'b0;
    check("t6_misalign", 32'(o_misalign), EXP_MISALIGN);
    check("t6_c2_addr", o_imem_addr, 32'h200);
    tick(1);
    mem_en = 1'b0;
    check("t6_c3_misalign", 32'(o_misalign), 32'd0);
    check("t6_c3_pc", o_if_pc, 32'h200);
    end_test();

    // 7: PC wraps from 0xFFFF_FFFC to 0.
    addr_q = '{32'h100, 32'hFFFF_FFFC, 32'h0};
    if_q   = '{'{32'hFFFF_FFFC, 32'hFFFF_FFFC}, '{32'hA000_0000, 32'h0}};
    do_reset(0);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'hFFFF_FFFC;
    tick(1);
    i_redirect = 1'b0;
    check("t7_c2_addr", o_imem_addr, 32'hFFFF_FFFC);
    check("t7_c2_misalign", 32'(o_misalign), 32'd0);
    tick(1);
    check("t7_c3_addr", o_imem_addr, 32'h0);
    check("t7_c3_pc4", o_if_pc4, 32'h0);
    tick(1);
    mem_en = 1'b0;
    check("t7_c4_pc", o_if_pc, 32'h0);
    end_test();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
